reg_writeback_arbiter: RTL and testbench
========================================

Name: reg_writeback_arbiter

Overview:
- Upstream neighbour of the 32x32 register file. Merges two result producers onto the file's single write port (LE/RW/PW).
- src0 is the single-cycle ALU path and is written directly.
- src1 is the long-latency load/multi-cycle path. It is buffered in a DEPTH-entry queue and drains into free write-port cycles.
- Exports a per-register pending vector so the hazard/stall logic knows which registers have writes still in flight.

Parameters:
- DEPTH, 4: src1 queue entries; power of 2, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- src0_valid  input  1  ALU result valid.
- src0_ready  output  1  ALU result accepted this cycle.
- src0_rw  input  5  ALU destination register.
- src0_data  input  32  ALU result.
- src1_valid  input  1  long-latency result valid.
- src1_ready  output  1  long-latency result accepted this cycle.
- src1_rw  input  5  long-latency destination register.
- src1_data  input  32  long-latency result.
- wr_le  output  1  drives register file LE.
- wr_rw  output  5  drives register file RW.
- wr_pw  output  32  drives register file PW.
- pending  output  32  bit i set while a live write to register i is queued or held in the output stage.

Behaviour:
- Reset: queue empty, all entries dead, wr_le=0, wr_rw=0, wr_pw=0, pending=0. A reset mid-operation discards every queued or in-flight write.
- Handshakes: a transfer occurs when valid && ready at a clk edge. Producers hold payload stable while valid && !ready.
- Queue entry fields: rw[4:0], data[31:0], live bit. Strict FIFO order.
- Per-cycle write-port selection, in priority order:
  - (a) Queue full: head drains; src0_ready=0.
  - (b) Otherwise, if src0_valid: src0 writes; src0_ready=1.
  - (c) Otherwise, if queue non-empty: head drains.
  - (d) Otherwise: idle.
- src0_ready=0 only in case (a).
- Output stage is registered. The selection made at edge N appears on wr_* during cycle N+1, and the file commits at edge N+1.
  - Selected write is live and rw≠0: wr_le=1.
  - Otherwise: wr_le=0. wr_rw/wr_pw still load the selected values.
- src1_ready = (count < DEPTH). Accepting src1 and draining the head in the same cycle is allowed; count is unchanged.
- Accepted src1 with rw=0 is consumed and never enqueued.
- Kill rule: src0 is by contract younger than every queued entry. When src0 is accepted with rw≠0, every live queue entry with the same rw is killed (live cleared) in that cycle.
  - This includes the head draining in that same cycle, so it reaches the output with wr_le=0.
  - Killed entries still occupy their slot and drain normally with wr_le=0.
- src1 entry enqueued in the same cycle as an src0 to the same rw: the new entry is not killed (it is younger).
- pending[i] = (wr_le && wr_rw==i) OR (any live queue entry with rw==i). pending[0] is always 0. Combinational from state.
- count arithmetic: log2(DEPTH)+1 bits; head/tail pointers wrap modulo DEPTH.

Optional Feature:
- Macro: WB_FWD_EN.
- Enabled: adds ports fwd_ra (input, 5), fwd_hit (output, 1) and fwd_data (output, 32). Combinational lookup:
  - Youngest live queue entry with rw==fwd_ra wins.
  - Otherwise the output stage, if wr_le && wr_rw==fwd_ra.
  - Otherwise fwd_hit=0 and fwd_data=0.
  - fwd_ra=0 always gives fwd_hit=0.
- Disabled: the three ports and the lookup logic are absent. All other behaviour is identical.

Decomposition:
- Package wb_pkg:
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32.
  - typedef wb_entry_t {live, rw, data}.
- Sub-module wb_queue: FIFO storage with push/pop, full/empty/count, per-entry kill-by-address, pending-vector OR, and (under WB_FWD_EN) the youngest-match lookup.
- Top level holds the port-select logic and the output register.

Test Plan:
- Reset:
  - Hold reset 2 cycles with src0/src1 driven valid.
  - Outputs stay 0 and the queue stays empty; wr_le=0 the cycle after release.
- src0 only:
  - src0 R3=0xDEADBEEF at edge N.
  - Cycle N+1: wr_le=1, wr_rw=3, wr_pw=0xDEADBEEF; pending[3]=1 in that cycle only.
- Simultaneous:
  - src0 R4=0x4 and src1 R7=0x7 at the same edge.
  - Next cycle writes R4; the cycle after writes R7.
  - pending[7]=1 for 2 cycles.
- Full queue:
  - src0 continuously valid; push 5 src1 writes R8..R12 back-to-back.
  - src1_ready drops after 4 accepted.
  - Full forces one head drain (R8) with src0_ready=0 that cycle; then R12 is accepted.
- Kill:
  - Queue src1 R5=0x11, then src0 R5=0x22.
  - Only 0x22 is written to R5; the R5=0x11 entry drains with wr_le=0; pending[5] clears after the 0x22 write.
  - WB_FWD_EN: fwd_ra=5 returns 0x22 once src0 is in the output stage.
- r0:
  - src0 rw=0 gives wr_le=0 next cycle.
  - src1 rw=0 is accepted, not queued; count is unchanged.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths and the queue entry type for the register-file writeback path.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] rw;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // r0 is hardwired in the register file, so it never shows as pending.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rw);
    logic [NUM_REGS-1:0] v;
    v = '0;
    v[rw] = 1'b1;
    v[0] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/wb_queue.sv
// FIFO for long-latency writebacks with kill-by-address and a pending vector.
// WB_FWD_EN adds a youngest-live-match lookup for operand forwarding.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [REG_ADDR_W-1:0] push_rw_i,
  input  logic [DATA_W-1:0]     push_data_i,
  input  logic                  pop_i,
  input  logic                  kill_en_i,
  input  logic [REG_ADDR_W-1:0] kill_rw_i,
  output wb_entry_t             head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [AW:0]           count_o,
  output logic [NUM_REGS-1:0]   pending_o
`ifdef WB_FWD_EN
  ,
  input  logic [REG_ADDR_W-1:0] fwd_ra_i,
  output logic                  fwd_hit_o,
  output logic [DATA_W-1:0]     fwd_data_o
`endif
);

  wb_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   head_q, tail_q;
  logic [AW:0]     count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (kill_en_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem_q[i].rw == kill_rw_i) begin
            mem_q[i].live <= 1'b0;
          end
        end
      end
      // Vacated slots are cleared so the pending OR can scan every slot.
      if (pop_i) begin
        mem_q[head_q].live <= 1'b0;
        head_q <= head_q + 1'b1;
      end
      if (push_i) begin
        mem_q[tail_q] <= {1'b1, push_rw_i, push_data_i};
        tail_q <= tail_q + 1'b1;
      end
      count_q <= count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end
  end

  always_comb begin
    head_o = mem_q[head_q];
    if (kill_en_i && (mem_q[head_q].rw == kill_rw_i)) begin
      head_o.live = 1'b0;
    end
  end

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_q[i].live) begin
        pending_o = pending_o | reg_onehot(mem_q[i].rw);
      end
    end
  end

`ifdef WB_FWD_EN
  logic [AW-1:0] fwd_idx;

  // Walk oldest to youngest so the last match is the youngest.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    fwd_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + AW'(k);
      if ((k < int'(count_q)) && mem_q[fwd_idx].live &&
          (mem_q[fwd_idx].rw == fwd_ra_i) && (fwd_ra_i != '0)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = mem_q[fwd_idx].data;
      end
    end
  end
`endif

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Merges the ALU path and the queued long-latency path onto the register-file write port.
// WB_FWD_EN adds the fwd_ra/fwd_hit/fwd_data forwarding lookup.
module reg_writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  src0_valid,
  output logic                  src0_ready,
  input  logic [REG_ADDR_W-1:0] src0_rw,
  input  logic [DATA_W-1:0]     src0_data,
  input  logic                  src1_valid,
  output logic                  src1_ready,
  input  logic [REG_ADDR_W-1:0] src1_rw,
  input  logic [DATA_W-1:0]     src1_data,
  output logic                  wr_le,
  output logic [REG_ADDR_W-1:0] wr_rw,
  output logic [DATA_W-1:0]     wr_pw,
  output logic [NUM_REGS-1:0]   pending
`ifdef WB_FWD_EN
  ,
  input  logic [REG_ADDR_W-1:0] fwd_ra,
  output logic                  fwd_hit,
  output logic [DATA_W-1:0]     fwd_data
`endif
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t           q_head;
  logic                q_full, q_empty;
  logic [AW:0]         q_count;
  logic [NUM_REGS-1:0] q_pending;

  logic                q_push, q_pop, kill_en;
  logic                sel_valid;
  wb_entry_t           sel_entry;

  logic                  wr_le_q, wr_le_d;
  logic [REG_ADDR_W-1:0] wr_rw_q, wr_rw_d;
  logic [DATA_W-1:0]     wr_pw_q, wr_pw_d;

`ifdef WB_FWD_EN
  logic              q_fwd_hit;
  logic [DATA_W-1:0] q_fwd_data;
`endif

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push_i      (q_push),
    .push_rw_i   (src1_rw),
    .push_data_i (src1_data),
    .pop_i       (q_pop),
    .kill_en_i   (kill_en),
    .kill_rw_i   (src0_rw),
    .head_o      (q_head),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (q_count),
    .pending_o   (q_pending)
`ifdef WB_FWD_EN
    ,
    .fwd_ra_i    (fwd_ra),
    .fwd_hit_o   (q_fwd_hit),
    .fwd_data_o  (q_fwd_data)
`endif
  );

  // A full queue wins the port so src1 can never be starved by a busy ALU.
  always_comb begin
    sel_valid  = 1'b0;
    sel_entry  = '0;
    q_pop      = 1'b0;
    kill_en    = 1'b0;
    src0_ready = !q_full;
    if (q_full) begin
      q_pop     = 1'b1;
      sel_valid = 1'b1;
      sel_entry = q_head;
    end else if (src0_valid) begin
      sel_valid = 1'b1;
      sel_entry = {1'b1, src0_rw, src0_data};
      kill_en   = (src0_rw != '0);
    end else if (!q_empty) begin
      q_pop     = 1'b1;
      sel_valid = 1'b1;
      sel_entry = q_head;
    end
  end

  assign src1_ready = (q_count < (AW+1)'(DEPTH));
  assign q_push     = src1_valid && src1_ready && (src1_rw != '0);

  assign wr_le_d = sel_valid && sel_entry.live && (sel_entry.rw != '0);
  assign wr_rw_d = sel_valid ? sel_entry.rw   : wr_rw_q;
  assign wr_pw_d = sel_valid ? sel_entry.data : wr_pw_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_le_q <= 1'b0;
      wr_rw_q <= '0;
      wr_pw_q <= '0;
    end else begin
      wr_le_q <= wr_le_d;
      wr_rw_q <= wr_rw_d;
      wr_pw_q <= wr_pw_d;
    end
  end

  assign wr_le   = wr_le_q;
  assign wr_rw   = wr_rw_q;
  assign wr_pw   = wr_pw_q;
  assign pending = q_pending | (wr_le_q ? reg_onehot(wr_rw_q) : '0);

`ifdef WB_FWD_EN
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (q_fwd_hit) begin
      fwd_hit  = 1'b1;
      fwd_data = q_fwd_data;
    end else if (wr_le_q && (wr_rw_q == fwd_ra) && (fwd_ra != '0)) begin
      fwd_hit  = 1'b1;
      fwd_data = wr_pw_q;
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed self-checking bench for reg_writeback_arbiter (DEPTH=4).
module tb_reg_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        src0_valid, src0_ready;
  logic [4:0]  src0_rw;
  logic [31:0] src0_data;
  logic        src1_valid, src1_ready;
  logic [4:0]  src1_rw;
  logic [31:0] src1_data;
  logic        wr_le;
  logic [4:0]  wr_rw;
  logic [31:0] wr_pw;
  logic [31:0] pending;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_ra;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_writeback_arbiter #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .src0_valid (src0_valid),
    .src0_ready (src0_ready),
    .src0_rw    (src0_rw),
    .src0_data  (src0_data),
    .src1_valid (src1_valid),
    .src1_ready (src1_ready),
    .src1_rw    (src1_rw),
    .src1_data  (src1_data),
    .wr_le      (wr_le),
    .wr_rw      (wr_rw),
    .wr_pw      (wr_pw),
    .pending    (pending)
`ifdef WB_FWD_EN
    ,
    .fwd_ra     (fwd_ra),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic le, input logic [4:0] rw,
                         input logic [31:0] pw);
    chk({tag, ".wr_le"}, {31'd0, wr_le}, {31'd0, le});
    chk({tag, ".wr_rw"}, {27'd0, wr_rw}, {27'd0, rw});
    chk({tag, ".wr_pw"}, wr_pw, pw);
  endtask

  function automatic logic [31:0] qcount();
    return {29'd0, dut.u_queue.count_o};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    src0_valid = 1'b1; src0_rw = 5'd3; src0_data = 32'h1;
    src1_valid = 1'b1; src1_rw = 5'd9; src1_data = 32'h9;
`ifdef WB_FWD_EN
    fwd_ra = 5'd0;
`endif

    // Reset held two cycles with both producers valid
    tick();
    tick();
    chk("rst.wr_le", {31'd0, wr_le}, 32'd0);
    chk("rst.pending", pending, 32'd0);
    chk("rst.count", qcount(), 32'd0);
    reset = 1'b0;
    src0_valid = 1'b0; src1_valid = 1'b0;
    tick();
    chk_out("post_rst", 1'b0, 5'd0, 32'd0);
    chk("post_rst.count", qcount(), 32'd0);

    // src0 only
    src0_valid = 1'b1; src0_rw = 5'd3; src0_data = 32'hDEADBEEF;
    chk("s0.src0_ready", {31'd0, src0_ready}, 32'd1);
    tick();
    src0_valid = 1'b0;
    chk_out("s0.n1", 1'b1, 5'd3, 32'hDEADBEEF);
    chk("s0.pending", pending, 32'h0000_0008);
    tick();
    chk("s0.n2.wr_le", {31'd0, wr_le}, 32'd0);
    chk("s0.n2.pending", pending, 32'd0);

    // Simultaneous src0 R4 and src1 R7
    src0_valid = 1'b1; src0_rw = 5'd4; src0_data = 32'h4;
    src1_valid = 1'b1; src1_rw = 5'd7; src1_data = 32'h7;
    tick();
    src0_valid = 1'b0; src1_valid = 1'b0;
    chk_out("sim.n1", 1'b1, 5'd4, 32'h4);
    chk("sim.n1.pending", pending, 32'h0000_0090);
    tick();
    chk_out("sim.n2", 1'b1, 5'd7, 32'h7);
    chk("sim.n2.pending", pending, 32'h0000_0080);
    tick();
    chk("sim.n3.wr_le", {31'd0, wr_le}, 32'd0);
    chk("sim.n3.pending", pending, 32'd0);

    // Full queue: src0 streams R20 while src1 pushes R8..R12
    src0_valid = 1'b1; src0_rw = 5'd20; src0_data = 32'h100;
    src1_valid = 1'b1; src1_rw = 5'd8; src1_data = 32'h80;
    chk("full.a.src1_ready", {31'd0, src1_ready}, 32'd1);
    tick();
    chk_out("full.a", 1'b1, 5'd20, 32'h100);
    chk("full.a.count", qcount(), 32'd1);
    src1_rw = 5'd9;  src1_data = 32'h90;
    tick();
    chk("full.b.count", qcount(), 32'd2);
    src1_rw = 5'd10; src1_data = 32'hA0;
    tick();
    chk("full.c.count", qcount(), 32'd3);
    src1_rw = 5'd11; src1_data = 32'hB0;
    tick();
    chk("full.d.count", qcount(), 32'd4);
    chk("full.d.wr_rw", {27'd0, wr_rw}, 32'd20);
    src1_rw = 5'd12; src1_data = 32'hC0;
    chk("full.e.src1_ready", {31'd0, src1_ready}, 32'd0);
    chk("full.e.src0_ready", {31'd0, src0_ready}, 32'd0);
    tick();
    chk_out("full.e", 1'b1, 5'd8, 32'h80);
    chk("full.e.count", qcount(), 32'd3);
    chk("full.e.pending", pending, 32'h0000_0F00);
    chk("full.f.src0_ready", {31'd0, src0_ready}, 32'd1);
    chk("full.f.src1_ready", {31'd0, src1_ready}, 32'd1);
    tick();
    src0_valid = 1'b0; src1_valid = 1'b0;
    chk_out("full.f", 1'b1, 5'd20, 32'h100);
    chk("full.f.count", qcount(), 32'd4);
    chk("full.f.pending", pending, 32'h0010_1E00);
    tick();
    chk_out("full.drain9", 1'b1, 5'd9, 32'h90);
    tick();
    chk_out("full.drain10", 1'b1, 5'd10, 32'hA0);
    tick();
    chk_out("full.drain11", 1'b1, 5'd11, 32'hB0);
    tick();
    chk_out("full.drain12", 1'b1, 5'd12, 32'hC0);
    chk("full.drain12.count", qcount(), 32'd0);
    tick();
    chk("full.idle.wr_le", {31'd0, wr_le}, 32'd0);
    chk("full.idle.pending", pending, 32'd0);

    // Kill: queued R5=0x11 superseded by src0 R5=0x22
    src1_valid = 1'b1; src1_rw = 5'd5; src1_data = 32'h11;
    tick();
    src1_valid = 1'b0;
    chk("kill.q.wr_le", {31'd0, wr_le}, 32'd0);
    chk("kill.q.pending", pending, 32'h0000_0020);
    src0_valid = 1'b1; src0_rw = 5'd5; src0_data = 32'h22;
    tick();
    src0_valid = 1'b0;
    chk_out("kill.s0", 1'b1, 5'd5, 32'h22);
    chk("kill.s0.pending", pending, 32'h0000_0020);
`ifdef WB_FWD_EN
    fwd_ra = 5'd5;
    #1;
    chk("kill.fwd_hit", {31'd0, fwd_hit}, 32'd1);
    chk("kill.fwd_data", fwd_data, 32'h22);
`endif
    tick();
    chk_out("kill.dead", 1'b0, 5'd5, 32'h11);
    chk("kill.dead.pending", pending, 32'd0);
    chk("kill.dead.count", qcount(), 32'd0);
`ifdef WB_FWD_EN
    chk("kill.dead.fwd_hit", {31'd0, fwd_hit}, 32'd0);
`endif
    tick();

    // r0 handling
    src0_valid = 1'b1; src0_rw = 5'd0; src0_data = 32'h5;
    tick();
    src0_valid = 1'b0;
    chk("r0.s0.wr_le", {31'd0, wr_le}, 32'd0);
    src1_valid = 1'b1; src1_rw = 5'd0; src1_data = 32'h6;
    chk("r0.s1.src1_ready", {31'd0, src1_ready}, 32'd1);
    tick();
    src1_valid = 1'b0;
    chk("r0.s1.count", qcount(), 32'd0);
    chk("r0.s1.pending", pending, 32'd0);
    tick();
    chk("r0.s1.wr_le", {31'd0, wr_le}, 32'd0);

    // Reset mid-operation discards queued writes
    src1_valid = 1'b1; src1_rw = 5'd6; src1_data = 32'h66;
    tick();
    src1_valid = 1'b0;
    chk("mrst.pre.pending", pending, 32'h0000_0040);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst.count", qcount(), 32'd0);
    chk("mrst.pending", pending, 32'd0);
    tick();
    chk("mrst.wr_le", {31'd0, wr_le}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
